load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_if.sv | 26 ++
 rtl/load_store_unit.sv | 154 +++++++++++++++
 tb/tb_load_store_unit.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Bus bundle between the CPU, the load/store unit and the word-wide data memory.
// The LSU takes the slave side; the CPU/memory environment takes the master side.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        output req_valid, req_op, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word loads and stores onto a word-wide memory,
// with sub-word stores done as read-modify-write and misaligned requests rejected.
//
// state | meaning
// IDLE  | ready for a request
// RD    | reading the aligned word (load data or merge base)
// WR    | one-cycle word write strobe
// RSP   | one-cycle response pulse
module load_store_unit (
    input logic              clk,
    input logic              reset,
    load_store_unit_if.slave bus
);
    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;

    typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;

    state_t      state, state_nxt;
    logic [2:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] word_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;

    logic        accept;
    logic        misaligned;
    logic        load_q;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic [31:0] store_data;

    assign accept = bus.req_valid && (state == IDLE);
    assign load_q = (op_q <= OP_LBU);

    always_comb begin
        misaligned = 1'b0;
        case (bus.req_op)
            OP_LW, OP_SW:         misaligned = (bus.req_addr[1:0] != 2'b00);
            OP_LH, OP_LHU, OP_SH: misaligned = bus.req_addr[0];
            default:              misaligned = 1'b0;
        endcase
    end

    // Load result is formed straight from mem_rdata so it is ready at the RD->RSP edge.
    always_comb begin
        byte_sel = 8'h00;
        case (addr_q[1:0])
            2'd0:    byte_sel = bus.mem_rdata[7:0];
            2'd1:    byte_sel = bus.mem_rdata[15:8];
            2'd2:    byte_sel = bus.mem_rdata[23:16];
            default: byte_sel = bus.mem_rdata[31:24];
        endcase
        half_sel = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (op_q)
            OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_data = {16'h0000, half_sel};
            OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_data = {24'h000000, byte_sel};
            default: load_data = bus.mem_rdata;
        endcase
    end

    always_comb begin
        store_data = word_q;
        case (op_q)
            OP_SW: store_data = wdata_q;
            OP_SH: begin
                if (addr_q[1]) store_data[31:16] = wdata_q[15:0];
                else           store_data[15:0]  = wdata_q[15:0];
            end
            OP_SB: begin
                case (addr_q[1:0])
                    2'd0:    store_data[7:0]   = wdata_q[7:0];
                    2'd1:    store_data[15:8]  = wdata_q[7:0];
                    2'd2:    store_data[23:16] = wdata_q[7:0];
                    default: store_data[31:24] = wdata_q[7:0];
                endcase
            end
            default: store_data = word_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (misaligned)              state_nxt = RSP;
                    else if (bus.req_op == OP_SW) state_nxt = WR;
                    else                         state_nxt = RD;
                end
            end
            RD:      state_nxt = load_q ? RSP : WR;
            WR:      state_nxt = RSP;
            RSP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q         <= 3'd0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            word_q       <= 32'h0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= bus.req_op;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                if (misaligned) begin
                    resp_rdata_q <= 32'h0;
                    resp_err_q   <= 1'b1;
                end
            end
            if (state == RD) begin
                word_q <= bus.mem_rdata;
                if (load_q) begin
                    resp_rdata_q <= load_data;
                    resp_err_q   <= 1'b0;
                end
            end
            if (state == WR) begin
                resp_rdata_q <= 32'h0;
                resp_err_q   <= 1'b0;
            end
        end
    end

    // Strobes decode directly from the state so an async reset kills them at once.
    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RSP);
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.mem_we     = (state == WR);
    assign bus.mem_addr   = {addr_q[31:2], 2'b00};
    assign bus.mem_wdata  = (state == WR) ? store_data : 32'h0;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 64-word behavioural data memory.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    logic [31:0] mem [0:63];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_idx = 6'd0;
    logic [31:0] pl_data = 32'h0;

    load_store_unit_if bus ();

    load_store_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.mem_rdata = mem[bus.mem_addr[7:2]];

    always @(posedge clk) begin
        if (bus.mem_we)  mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
        else if (pl_en)  mem[pl_idx] <= pl_data;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] data);
        pl_en   = 1'b1;
        pl_idx  = addr[7:2];
        pl_data = data;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    // Called on a negedge in IDLE; returns on the negedge of the IDLE cycle after RSP.
    task automatic do_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         output int lat, output logic [31:0] rdata, output logic err,
                         output int we_cnt, output int we_k, output logic [31:0] we_data,
                         output logic [31:0] we_addr);
        lat = 0; rdata = 32'h0; err = 1'b0;
        we_cnt = 0; we_k = 0; we_data = 32'h0; we_addr = 32'h0;
        check("ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (bus.mem_we) begin
                we_cnt++;
                we_k    = k;
                we_data = bus.mem_wdata;
                we_addr = bus.mem_addr;
            end
            if (bus.resp_valid) begin
                lat   = k;
                rdata = bus.resp_rdata;
                err   = bus.resp_err;
                break;
            end
            @(negedge clk);
        end
        if (lat == 0) check("resp_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic load_chk(input string tag, input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] exp);
        int lat, wc, wk;
        logic [31:0] rd, wdv, wav;
        logic er;
        do_op(op, addr, 32'h0, lat, rd, er, wc, wk, wdv, wav);
        check({tag, "_lat"}, 32'(lat), 32'd2);
        check({tag, "_rdata"}, rd, exp);
        check({tag, "_err"}, 32'(er), 32'd0);
        check({tag, "_we"}, 32'(wc), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat, wc, wk, pulses;
        logic [31:0] rd, wdv, wav, r1, r2;
        logic er;
        logic [6:0] rdy_v, rsp_v;

        bus.req_valid = 1'b0;
        bus.req_op    = 3'd0;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;

        // reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", 32'(bus.req_ready), 32'd1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'h0);
        check("rst_resp_err", 32'(bus.resp_err), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_mem_wdata", bus.mem_wdata, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        // SW
        do_op(3'd5, 32'h10, 32'hDEADBEEF, lat, rd, er, wc, wk, wdv, wav);
        check("sw_lat", 32'(lat), 32'd2);
        check("sw_we_cnt", 32'(wc), 32'd1);
        check("sw_we_cycle", 32'(wk), 32'd1);
        check("sw_mem_wdata", wdv, 32'hDEADBEEF);
        check("sw_mem_addr", wav, 32'h10);
        check("sw_rdata", rd, 32'h0);
        check("sw_err", 32'(er), 32'd0);
        check("sw_mem", mem[4], 32'hDEADBEEF);
        check("idle_mem_wdata", bus.mem_wdata, 32'h0);

        // loads with lane selection and extension
        preload(32'h10, 32'h8899AABB);
        load_chk("lb12", 3'd3, 32'h12, 32'hFFFFFF99);
        load_chk("lbu12", 3'd4, 32'h12, 32'h00000099);
        load_chk("lh12", 3'd1, 32'h12, 32'hFFFF8899);
        load_chk("lhu10", 3'd2, 32'h10, 32'h0000AABB);
        load_chk("lw10", 3'd0, 32'h10, 32'h8899AABB);
        load_chk("lb13", 3'd3, 32'h13, 32'hFFFFFF88);
        load_chk("lb10", 3'd3, 32'h10, 32'hFFFFFFBB);
        load_chk("lh10", 3'd1, 32'h10, 32'hFFFFAABB);
        load_chk("lbu11", 3'd4, 32'h11, 32'h000000AA);

        // read-modify-write stores
        preload(32'h20, 32'h11223344);
        do_op(3'd7, 32'h21, 32'h000000A5, lat, rd, er, wc, wk, wdv, wav);
        check("sb_lat", 32'(lat), 32'd3);
        check("sb_we_cnt", 32'(wc), 32'd1);
        check("sb_we_cycle", 32'(wk), 32'd2);
        check("sb_mem_wdata", wdv, 32'h1122A544);
        check("sb_mem_addr", wav, 32'h20);
        check("sb_err", 32'(er), 32'd0);
        load_chk("lw20_after_sb", 3'd0, 32'h20, 32'h1122A544);
        do_op(3'd6, 32'h22, 32'h1234BEEF, lat, rd, er, wc, wk, wdv, wav);
        check("sh_lat", 32'(lat), 32'd3);
        check("sh_mem_wdata", wdv, 32'hBEEFA544);
        check("sh_we_cnt", 32'(wc), 32'd1);
        load_chk("lw20_after_sh", 3'd0, 32'h20, 32'hBEEFA544);

        // misaligned requests
        preload(32'h00, 32'hCAFEF00D);
        preload(32'h04, 32'h55667788);
        do_op(3'd0, 32'h06, 32'h0, lat, rd, er, wc, wk, wdv, wav);
        check("lw_mis_lat", 32'(lat), 32'd1);
        check("lw_mis_err", 32'(er), 32'd1);
        check("lw_mis_rdata", rd, 32'h0);
        check("lw_mis_we", 32'(wc), 32'd0);
        check("lw_mis_err_hold", 32'(bus.resp_err), 32'd1);
        do_op(3'd6, 32'h03, 32'h0000FFFF, lat, rd, er, wc, wk, wdv, wav);
        check("sh_mis_lat", 32'(lat), 32'd1);
        check("sh_mis_err", 32'(er), 32'd1);
        check("sh_mis_we", 32'(wc), 32'd0);
        check("sh_mis_mem", mem[0], 32'hCAFEF00D);
        load_chk("lb_odd_ok", 3'd3, 32'h07, 32'h00000055);

        // back-to-back with req_valid held high
        rdy_v = '0;
        rsp_v = '0;
        pulses = 0;
        r1 = 32'h0;
        r2 = 32'h0;
        bus.req_valid = 1'b1;
        bus.req_op    = 3'd0;
        bus.req_addr  = 32'h10;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            rdy_v[c-1] = bus.req_ready;
            rsp_v[c-1] = bus.resp_valid;
            if (bus.resp_valid) begin
                pulses++;
                if (pulses == 1) r1 = bus.resp_rdata;
                else             r2 = bus.resp_rdata;
            end
            if (c == 1) bus.req_addr = 32'h20;
            if (c == 4) bus.req_valid = 1'b0;
        end
        check("b2b_ready_pattern", 32'(rdy_v), 32'h64);
        check("b2b_resp_pattern", 32'(rsp_v), 32'h12);
        check("b2b_pulses", 32'(pulses), 32'd2);
        check("b2b_rdata1", r1, 32'h8899AABB);
        check("b2b_rdata2", r2, 32'hBEEFA544);

        // reset asserted during the write cycle of an SB
        preload(32'h20, 32'h11223344);
        bus.req_valid = 1'b1;
        bus.req_op    = 3'd7;
        bus.req_addr  = 32'h21;
        bus.req_wdata = 32'h000000A5;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("rstwr_rd_we", 32'(bus.mem_we), 32'd0);
        @(negedge clk);
        check("rstwr_wr_we", 32'(bus.mem_we), 32'd1);
        reset = 1'b0;
        #1;
        check("rstwr_we_drop", 32'(bus.mem_we), 32'd0);
        check("rstwr_ready", 32'(bus.req_ready), 32'd1);
        check("rstwr_wdata", bus.mem_wdata, 32'h0);
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.resp_valid) pulses++;
        end
        check("rstwr_no_resp", 32'(pulses), 32'd0);
        check("rstwr_mem", mem[8], 32'h11223344);
        check("rstwr_mem_addr", bus.mem_addr, 32'h0);
        reset = 1'b1;
        load_chk("post_rst_lw", 3'd0, 32'h20, 32'h11223344);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
